// File: rtl/fp_alu_pkg.sv
// Shared constants and Dadda-tree helpers for the FP ALU mantissa datapath.
// The reduction schedule is derived from DADDA_H so the tree follows the height table.
package fp_alu_pkg;

    localparam int MANT_W    = 24;
    localparam int PROD_W    = 48;
    localparam int DADDA_N   = 8;
    localparam int DADDA_H [DADDA_N] = '{2, 3, 4, 6, 9, 13, 19, 28};
    localparam int S1_LEVELS = 4;

    function automatic int top_level();
        int lvl;
        lvl = 0;
        for (int k = 0; k < DADDA_N; k++) begin
            if (DADDA_H[k] < MANT_W) lvl = k;
        end
        return lvl;
    endfunction

    localparam int TOP_LVL = top_level();
    localparam int P1_IDX  = TOP_LVL - S1_LEVELS + 1;
    localparam int P1_H    = DADDA_H[P1_IDX];

    // Column c holds its live bits in slots [0 .. height-1]; the rest are zero.
    typedef logic [PROD_W-1:0][MANT_W-1:0] col_t;
    typedef logic [PROD_W-1:0][P1_H-1:0]   p1_t;
    typedef int height_t [PROD_W];
    typedef struct packed {
        logic [PROD_W-1:0] a;
        logic [PROD_W-1:0] b;
    } rows_t;

    function automatic void init_heights(output height_t h);
        for (int c = 0; c < PROD_W; c++) begin
            h[c] = (c < MANT_W) ? c + 1 : 2 * MANT_W - 1 - c;
        end
    endfunction

    // One Dadda level: per column, just enough FA/HA cells so that the
    // surviving bits plus incoming carries fit within target d.
    function automatic void dadda_level(inout col_t b, inout height_t h, input int d);
        col_t               bo;
        height_t            ho;
        logic [MANT_W-1:0]  cin_b;
        logic [MANT_W-1:0]  cout_b;
        int                 ncin, ncout, e, fa, ha, idx, k;
        bo    = '0;
        cin_b = '0;
        ncin  = 0;
        for (int c = 0; c < PROD_W; c++) begin
            e      = h[c] + ncin - d;
            fa     = (e > 0) ? e / 2 : 0;
            ha     = (e > 0) ? e % 2 : 0;
            idx    = 0;
            k      = 0;
            cout_b = '0;
            ncout  = 0;
            for (int f = 0; f < fa; f++) begin
                bo[c][k]      = b[c][idx] ^ b[c][idx+1] ^ b[c][idx+2];
                cout_b[ncout] = (b[c][idx] & b[c][idx+1]) | (b[c][idx] & b[c][idx+2])
                              | (b[c][idx+1] & b[c][idx+2]);
                k     = k + 1;
                ncout = ncout + 1;
                idx   = idx + 3;
            end
            for (int f = 0; f < ha; f++) begin
                bo[c][k]      = b[c][idx] ^ b[c][idx+1];
                cout_b[ncout] = b[c][idx] & b[c][idx+1];
                k     = k + 1;
                ncout = ncout + 1;
                idx   = idx + 2;
            end
            for (int r = idx; r < h[c]; r++) begin
                bo[c][k] = b[c][r];
                k = k + 1;
            end
            for (int r = 0; r < ncin; r++) begin
                bo[c][k] = cin_b[r];
                k = k + 1;
            end
            ho[c] = k;
            cin_b = cout_b;
            ncin  = ncout;
        end
        b = bo;
        h = ho;
    endfunction

    function automatic p1_t stage1_reduce(input logic [MANT_W-1:0] x, input logic [MANT_W-1:0] y);
        col_t    b;
        height_t h;
        p1_t     s;
        b = '0;
        for (int c = 0; c < PROD_W; c++) h[c] = 0;
        for (int i = 0; i < MANT_W; i++) begin
            for (int j = 0; j < MANT_W; j++) begin
                b[i+j][h[i+j]] = x[j] & y[i];
                h[i+j] = h[i+j] + 1;
            end
        end
        for (int l = TOP_LVL; l >= P1_IDX; l--) dadda_level(b, h, DADDA_H[l]);
        for (int c = 0; c < PROD_W; c++) s[c] = b[c][P1_H-1:0];
        return s;
    endfunction

    // Heights at the register boundary are replayed from the static schedule.
    function automatic rows_t stage2_reduce(input p1_t s);
        col_t    b;
        col_t    shape;
        height_t h;
        rows_t   r;
        init_heights(h);
        shape = '0;
        for (int l = TOP_LVL; l >= P1_IDX; l--) dadda_level(shape, h, DADDA_H[l]);
        b = '0;
        for (int c = 0; c < PROD_W; c++) b[c][P1_H-1:0] = s[c];
        for (int l = P1_IDX - 1; l >= 0; l--) dadda_level(b, h, DADDA_H[l]);
        for (int c = 0; c < PROD_W; c++) begin
            r.a[c] = b[c][0];
            r.b[c] = b[c][1];
        end
        return r;
    endfunction

endpackage

// File: rtl/ksa_nbits.sv
// Combinational Kogge-Stone adder, carry-in 0, carry-out dropped.
// Prefix distance doubles each level, giving log2(WIDTH) levels.
module ksa_nbits #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out
);

    function automatic logic [WIDTH-1:0] ks_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g, p, gn, pn, hs;
        g  = a & b;
        p  = a ^ b;
        hs = p;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        return hs ^ {g[WIDTH-2:0], 1'b0};
    endfunction

    // Prefix-tree sum
    always_comb begin
        out = ks_sum(in1, in2);
    end

endmodule

// File: rtl/dadda_multiplier_24bit_pipelined.sv
// Unsigned 24x24->48 Dadda multiplier, two pipeline stages (P1 at height 6, P2 = out).
// Inputs sampled on edge k produce out after edge k+1.
module dadda_multiplier_24bit_pipelined
    import fp_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [MANT_W-1:0] in1,
    input  logic [MANT_W-1:0] in2,
    output logic [PROD_W-1:0] out
);

    p1_t               p1_next;
    p1_t               p1;
    rows_t             rows;
    logic [PROD_W-1:0] sum;

    // Partial products and the first four reduction levels
    always_comb begin
        p1_next = stage1_reduce(in1, in2);
    end

    // P1: six-row intermediate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p1 <= '0;
        else     p1 <= p1_next;
    end

    // Remaining levels down to two rows
    always_comb begin
        rows = stage2_reduce(p1);
    end

    ksa_nbits #(.WIDTH(PROD_W)) u_ksa (
        .in1 (rows.a),
        .in2 (rows.b),
        .out (sum)
    );

    // P2: registered product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out <= '0;
        else     out <= sum;
    end

endmodule

// File: tb/tb_dadda_multiplier_24bit_pipelined.sv
// Directed and streaming checks of the 2-cycle 24x24 multiplier, including async reset.
module tb_dadda_multiplier_24bit_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in1;
    logic [23:0] in2;
    logic [47:0] out;

    int          total = 0;
    int          bad   = 0;
    logic [47:0] prev_exp;
    string       prev_tag;
    bit          prev_valid;

    dadda_multiplier_24bit_pipelined dut (
        .clk (clk),
        .rst (rst),
        .in1 (in1),
        .in2 (in2),
        .out (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one pair; after the edge, out must hold the pair from the previous call.
    task automatic cycle(input logic [23:0] a, input logic [23:0] b, input logic [47:0] e, input string tag);
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
        if (prev_valid) chk(prev_tag, out, prev_exp);
        prev_exp   = e;
        prev_tag   = tag;
        prev_valid = 1'b1;
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        rst        = 1'b1;
        in1        = 24'h0;
        in2        = 24'h0;
        prev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, 48'h0);
        @(negedge clk);
        rst        = 1'b0;
        prev_valid = 1'b1;
        prev_exp   = 48'h0;
        prev_tag   = "post_reset_0";

        cycle(24'h000000, 24'h000000, 48'h000000000000, "post_reset_1");
        cycle(24'h000000, 24'hFFFFFF, 48'h000000000000, "zero");
        cycle(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max");
        cycle(24'h800000, 24'hABCDEF, 48'h55E6F7800000, "q123_id");
        cycle(24'hC00000, 24'hAAAAAA, 48'h7FFFFF800000, "q123_c0");
        cycle(24'h000001, 24'h000001, 48'h000000000001, "one");
        cycle(24'h123456, 24'h000010, 48'h000001234560, "shift4");
        cycle(24'h000003, 24'h000005, 48'h00000000000F, "small");
        cycle(24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, "max_x1");

        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 24; j++) begin
                cycle(24'h1 << i, 24'h1 << j, 48'h1 << (i + j), $sformatf("walk_%0d_%0d", i, j));
            end
        end

        for (int n = 0; n < 1000; n++) begin
            a = 24'($urandom());
            b = 24'($urandom());
            cycle(a, b, {24'h0, a} * {24'h0, b}, $sformatf("rand_%0d", n));
        end

        // Two products are in flight here; reset drops them asynchronously.
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", out, 48'h0);
        in1 = 24'h0;
        in2 = 24'h0;
        @(posedge clk);
        #1;
        chk("rst_hold", out, 48'h0);
        @(negedge clk);
        rst        = 1'b0;
        prev_valid = 1'b1;
        prev_exp   = 48'h0;
        prev_tag   = "rst_first_edge";

        cycle(24'h000ABC, 24'h000100, 48'h0000000ABC00, "post_rst_prod");
        cycle(24'h000000, 24'h000000, 48'h000000000000, "flush0");
        cycle(24'h000000, 24'h000000, 48'h000000000000, "flush1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dadda_multiplier_24bit_pipelined.md
# dadda_multiplier_24bit_pipelined

Unsigned 24×24→48-bit pipelined multiplier using Dadda-tree partial-product reduction and a Kogge-Stone final adder. It is the multiply engine of the FP ALU mantissa datapath, including the Newton-Raphson reciprocal stages, where it computes Q1.23 × Q1.23 → Q2.46. It has fixed 2-cycle latency and accepts one new operand pair every cycle.

## Interface
- Parameters: none.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all pipeline registers.
- `in1`  in  24  multiplicand, unsigned (Q1.23 in mantissa use).
- `in2`  in  24  multiplier, unsigned (Q1.23 in mantissa use).
- `out`  out  48  registered product `in1*in2`, unsigned (Q2.46); exact, no rounding or truncation.

## Operation
- Partial products: `pp[i][j] = in1[j] & in2[i]`, 24 rows, weight i+j.
- Dadda reduction uses the height sequence 28, 19, 13, 9, 6, 4, 3, 2. For 24 rows this means 7 reduction levels: 24→19→13→9→6→4→3→2.
  - Each level uses full adders (3:2) and half adders (2:2) only.
  - Each level uses the minimum counters needed per column to meet the target height.
- The final two 48-bit rows are summed by `ksa_nbits` with WIDTH=48. The carry-out is discarded; it is always 0 because the max product is 0xFFFFFE000001.
- The result is bit-exact versus `in1*in2` for all 2^48 input pairs.
- No valid/enable/stall: every cycle is a new sample. The parent carries valid flags alongside in its own pipeline.
- No sign handling: sign, rounding and normalization belong to the caller (e.g. `q1_23_fixed_point_rounder` downstream).

## Timing
- Pipeline register P1, after reduction to height 6 (4 levels), holds the 6 partial rows. It is 6×48 bits; constant-zero bits may be trimmed.
- Register P2 is `out`. It is loaded with the KSA sum after the remaining 3 levels (6→4→3→2) plus the 48-bit KSA.
- Latency: operands present before rising edge k appear on `out` after edge k+1. `out` is stable through cycle k+2 (2-cycle latency).
- Throughput: 1 product per clock. Back-to-back inputs produce back-to-back outputs in order.
- Reset value: P1 = 0 and `out` = 48'h0.
- Reset asserted mid-stream discards all in-flight products immediately (asynchronous).
- After deassertion, `out` stays 0 until 2 edges have consumed new inputs. With inputs held at 0 during reset, the first two post-reset outputs are 0.
- Each pipeline stage's critical path is no longer than about 4 FA delays, or 3 FA delays plus the log2(48)=6-level KSA.

## Structure
- Sub-module `ksa_nbits #(WIDTH)` has ports `in1`, `in2` (WIDTH), `out` (WIDTH). It is a combinational Kogge-Stone adder with cin = 0 and no carry-out port, and is reused elsewhere, e.g. by the 28-bit subtractor in the reciprocal.
- FA/HA cells are local modules or inline expressions.
- The shared package `fp_alu_pkg` holds:
  - `MANT_W` = 24;
  - `PROD_W` = 48;
  - the Dadda height constant array {2,3,4,6,9,13,19,28}.
- The reduction tree is generated from the package constants, not hand-listed.

## Test plan
- Zero: in1 = 0x000000, in2 = 0xFFFFFF → out = 0x000000000000 two cycles later.
- Max: in1 = in2 = 0xFFFFFF → out = 0xFFFFFE000001; no carry lost.
- Q1.23 identity: in1 = 0x800000, in2 = 0xABCDEF → out = 0x55E6F7800000. Also in1 = 0xC00000, in2 = 0xAAAAAA → 0x7FFFFF800000.
- Streaming: change the operand pair every cycle for 1,000 random pairs.
  - Each `out` equals the golden product of the pair applied exactly 2 edges earlier.
  - No bubbles and no reordering.
- Reset mid-operation: assert `rst` asynchronously between edges with two products in flight.
  - `out` goes to 0 immediately and stays 0 through reset.
  - Post-reset, the first product appears on the 2nd edge after new inputs are applied.
- Walking ones: in1 = 1<<i, in2 = 1<<j for all i, j in 0..23 → out = 1<<(i+j). This covers every column of the tree.
